// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions.
// Holds the default map geometry and sample width used by the pooling stage
// and its neighbours, plus the signed sample type and the pooled coordinate width.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int CNT_W  = 3;

    // A pooled coordinate drops the low (parity) bit of the raster coordinate.
    localparam int POOL_W = CNT_W - 1;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle between the raster-scan producer and the 2x2 max-pool stage.
// Signals:
//   in_valid, in_data, in_col, in_row        : tagged input sample (producer -> pool)
//   out_valid, out_data, out_col, out_row    : pooled result (pool -> consumer)
//   frame_done                               : pulses with the last window of a frame
//   seq_err                                  : sticky raster-order error flag
// Modports: master = producer/consumer side, slave = pooling stage.
interface maxpool2x2_stream_if #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int CNT_W  = cnn_pkg::CNT_W
) ();

    localparam int POOL_W = CNT_W - 1;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]         in_col;
    logic [CNT_W-1:0]         in_row;

    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [POOL_W-1:0]        out_col;
    logic [POOL_W-1:0]        out_row;
    logic                     frame_done;
    logic                     seq_err;

    modport master (
        output in_valid, in_data, in_col, in_row,
        input  out_valid, out_data, out_col, out_row, frame_done, seq_err
    );

    modport slave (
        input  in_valid, in_data, in_col, in_row,
        output out_valid, out_data, out_col, out_row, frame_done, seq_err
    );

endinterface

// File: rtl/signed_max2.sv
// Combinational two-input signed maximum.
// Ports:
//   a, b : signed operands (DATA_W bits)
//   y    : the larger of a and b (either operand on a tie, same value)
module signed_max2 #(
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool stage fed by an 8x8 raster scan
// (column inner, row outer). One sample is consumed per in_valid cycle and one
// pooled value is emitted, registered, one cycle after each (odd,odd) sample.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (0 = in reset)
//   bus   : maxpool2x2_stream_if.slave stream bundle (input sample, pooled
//           output, frame_done, seq_err)
// Optional feature: define MAXPOOL_SEQ_CHECK_EN to track the expected raster
// coordinate and raise the sticky seq_err flag on an out-of-order sample.
// Without the macro seq_err is tied low and no tracking logic exists.
module maxpool2x2_stream #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int CNT_W  = cnn_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    maxpool2x2_stream_if.slave  bus
);

    localparam int POOL_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] rowbuf [IMG_W/2];
    logic signed [DATA_W-1:0] col_max;
    logic signed [DATA_W-1:0] row_max;
    logic [POOL_W-1:0]        k;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic [POOL_W-1:0]        out_col_q;
    logic [POOL_W-1:0]        out_row_q;
    logic                     frame_done_q;

    assign k = bus.in_col[CNT_W-1:1];

    // Column-pair stage: combines the held value with the current sample.
    signed_max2 #(.DATA_W(DATA_W)) u_col_max (
        .a (hold),
        .b (bus.in_data),
        .y (col_max)
    );

    // Row-pair stage: combines the even-row pair max stored for this window
    // with the current sample of the odd row.
    signed_max2 #(.DATA_W(DATA_W)) u_row_max (
        .a (rowbuf[k]),
        .b (bus.in_data),
        .y (row_max)
    );

    // Datapath steered by coordinate parity. Even rows fold each column pair
    // into rowbuf; odd rows fold rowbuf into hold and then finish the window.
    // Every rowbuf entry is rewritten on an even row before the odd row reads
    // it, so back-to-back frames need no flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
            for (int i = 0; i < IMG_W/2; i++) begin
                rowbuf[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                unique case ({bus.in_row[0], bus.in_col[0]})
                    2'b00: hold      <= bus.in_data;
                    2'b01: rowbuf[k] <= col_max;
                    2'b10: hold      <= row_max;
                    2'b11: begin
                        out_valid_q  <= 1'b1;
                        out_data_q   <= col_max;
                        out_col_q    <= bus.in_col[CNT_W-1:1];
                        out_row_q    <= bus.in_row[CNT_W-1:1];
                        frame_done_q <= (bus.in_row == LAST_ROW) &&
                                        (bus.in_col == LAST_COL);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_row    = out_row_q;
    assign bus.frame_done = frame_done_q;

`ifdef MAXPOOL_SEQ_CHECK_EN
    logic [CNT_W-1:0] exp_col;
    logic [CNT_W-1:0] exp_row;
    logic             seq_err_q;

    // Raster-order tracker. After any accepted sample the expectation becomes
    // the received coordinate plus one, so a single glitch is flagged once and
    // checking resumes from wherever the producer actually is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_col   <= '0;
            exp_row   <= '0;
            seq_err_q <= 1'b0;
        end else if (bus.in_valid) begin
            if ((bus.in_row != exp_row) || (bus.in_col != exp_col)) begin
                seq_err_q <= 1'b1;
            end
            if (bus.in_col == LAST_COL) begin
                exp_col <= '0;
                exp_row <= (bus.in_row == LAST_ROW) ? '0 : bus.in_row + 1'b1;
            end else begin
                exp_col <= bus.in_col + 1'b1;
                exp_row <= bus.in_row;
            end
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed self-checking bench for maxpool2x2_stream.
// Frames are driven as raster scans with closed-form pixel patterns; each
// pooled window's expected maximum is the hand-derived closed form for that
// pattern (bottom-right pixel for ascending data, top-left for descending).
module tb_maxpool2x2_stream;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic reset;

    int       checks;
    int       errors;
    int       done_count;
    int       last_out;
    logic     seq_exp;

    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    maxpool2x2_stream dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Input pixel for pattern 0 (ascending), 1 (negated) or 2 (100 minus index).
    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return r*8 + c;
            1:       return -(r*8 + c);
            default: return 100 - (r*8 + c);
        endcase
    endfunction

    // Window maxima worked out by hand: ascending data peaks at the
    // bottom-right pixel (2R+1, 2C+1), descending data at the top-left (2R, 2C).
    function automatic int pooled(input int pat, input int pr, input int pc);
        case (pat)
            0:       return 16*pr + 2*pc + 9;
            1:       return -(16*pr + 2*pc);
            default: return 100 - (16*pr + 2*pc);
        endcase
    endfunction

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input (called at a negedge) and returns at the next
    // negedge, by which point the sample has been accepted.
    task automatic apply_stimulus(input logic valid, input int r, input int c,
                                  input int data);
        bus.in_valid = valid;
        bus.in_row   = CNT_W'(r);
        bus.in_col   = CNT_W'(c);
        bus.in_data  = DATA_W'(data);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_valid"}, bus.out_valid, 0);
        check_output({tag, "_data"}, bus.out_data, 0);
        check_output({tag, "_row"}, bus.out_row, 0);
        check_output({tag, "_col"}, bus.out_col, 0);
        check_output({tag, "_done"}, bus.frame_done, 0);
        check_output({tag, "_seq"}, bus.seq_err, 0);
    endtask

    // Runs a raster frame up to linear index stop_at, optionally with an idle
    // cycle after each sample and optionally skipping one coordinate.
    task automatic run_frame(input int pat, input bit gap, input int stop_at,
                             input int skip_r, input int skip_c);
        bit odd;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r*8 + c > stop_at) return;
                if (r == skip_r && c == skip_c) continue;
                apply_stimulus(1'b1, r, c, pix(pat, r, c));
`ifdef MAXPOOL_SEQ_CHECK_EN
                if (skip_r >= 0 && (r > skip_r || (r == skip_r && c > skip_c)))
                    seq_exp = 1'b1;
`endif
                odd = (r % 2 == 1) && (c % 2 == 1);
                check_output("out_valid", bus.out_valid, 32'(odd));
                check_output("seq_err", bus.seq_err, 32'(seq_exp));
                if (odd) begin
                    last_out = pooled(pat, r/2, c/2);
                    check_output("out_data", bus.out_data, last_out);
                    check_output("out_row", bus.out_row, r/2);
                    check_output("out_col", bus.out_col, c/2);
                    check_output("frame_done", bus.frame_done,
                                 32'(r == 7 && c == 7));
                    if (bus.frame_done === 1'b1) done_count++;
                end else begin
                    check_output("hold_data", bus.out_data, last_out);
                    check_output("frame_done_idle", bus.frame_done, 0);
                end
                if (gap) begin
                    apply_stimulus(1'b0, 0, 0, 32767);
                    check_output("gap_valid", bus.out_valid, 0);
                    check_output("gap_data", bus.out_data, last_out);
                    check_output("gap_done", bus.frame_done, 0);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_count = 0;
        last_out   = 0;
        seq_exp    = 1'b0;
        reset      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        bus.in_col   = '0;
        bus.in_data  = '0;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        $display("[TB] two back-to-back frames, ascending then 100-minus");
        run_frame(0, 1'b0, 63, -1, -1);
        run_frame(2, 1'b0, 63, -1, -1);
        check_output("frame_done_count", done_count, 2);

        $display("[TB] negative data frame");
        run_frame(1, 1'b0, 63, -1, -1);

        $display("[TB] valid toggling every cycle");
        run_frame(0, 1'b1, 63, -1, -1);

        $display("[TB] reset mid-frame at row 3 col 5");
        run_frame(0, 1'b0, 3*8 + 5, -1, -1);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset    = 1'b1;
        last_out = 0;
        run_frame(0, 1'b0, 63, -1, -1);

        $display("[TB] frame with coordinate (2,4) skipped");
        run_frame(0, 1'b0, 63, 2, 4);
        apply_stimulus(1'b0, 0, 0, 0);
        check_output("seq_err_sticky", bus.seq_err, 32'(seq_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2/stride-2 signed max-pool stage, directly downstream of the 8x8 raster scan counter (inner = column, outer = row).
- Consumes one convolution result per enabled scan cycle, tagged with its (row, col) coordinate.
- Emits one pooled value per 2x2 window; an 8x8 map yields a 4x4 output with coordinates.
- Feeds the next layer's buffer.

Parameters:
- DATA_W, 16, signed sample width.
- IMG_W, 8, input map width (even, power of 2).
- IMG_H, 8, input map height (even).
- CNT_W, 3, coordinate width (log2 of IMG_W/IMG_H).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  sample qualifier (same signal as the scan counter's en).
- in_data  in  DATA_W  signed conv result.
- in_col  in  CNT_W  column index (scan counter inner).
- in_row  in  CNT_W  row index (scan counter outer).
- out_valid  out  1  single-cycle pulse, pooled result valid.
- out_data  out  DATA_W  signed pooled max.
- out_col  out  CNT_W-1  pooled column = in_col>>1.
- out_row  out  CNT_W-1  pooled row = in_row>>1.
- frame_done  out  1  pulses together with the out_valid of the last window.
- seq_err  out  1  sticky raster-order error (see Optional Feature).

Behaviour:
- Reset (reset=0, async): all outputs 0; hold register 0; row buffer (IMG_W/2 entries of DATA_W) cleared; seq_err 0.
- No backpressure. Every cycle with in_valid=1 is consumed. in_valid=0 cycles change no state, and out_valid=0.
- Datapath per accepted sample, by parity (r = in_row[0], c = in_col[0]), with k = in_col>>1:
  - r=0,c=0: hold <= in_data.
  - r=0,c=1: rowbuf[k] <= max(hold, in_data).
  - r=1,c=0: hold <= max(rowbuf[k], in_data).
  - r=1,c=1: result = max(hold, in_data).
- All comparisons are signed two's-complement. Ties select either operand; the value is identical.
- Latency: out_valid, out_data, out_row, out_col are registered. They assert on the clock edge after the accepting edge of the (odd,odd) sample. Output regs hold their value when out_valid=0.
- frame_done = 1 in the same cycle as out_valid when in_row=IMG_H-1 and in_col=IMG_W-1.
- Back-to-back frames: row 0 of the next frame follows row IMG_H-1 with no gap. No flush is needed; rowbuf entries are overwritten before being read.
- Reset mid-frame: the partial window is discarded. Processing restarts at any coordinate, but only windows whose four samples all arrive after reset produce correct data.
- Coordinates come from the upstream counter and are trusted for datapath steering.

Optional Feature:
- Macro: MAXPOOL_SEQ_CHECK_EN.
- With the macro: the block tracks the expected next (row, col) in raster order, wrapping col at IMG_W-1 and row at IMG_H-1. Expected value after reset is (0,0).
  - Any accepted sample with a mismatching coordinate sets seq_err, which stays set until reset.
  - The expected pointer then resynchronises to the received coordinate + 1.
  - The datapath is unaffected.
- Without the macro: no tracking logic; seq_err tied to 0.

Decomposition:
- Shared package `cnn_pkg`:
  - DATA_W, IMG_W, IMG_H, CNT_W defaults.
  - Signed sample typedef.
  - Pooled coordinate width constant (CNT_W-1).
- One sub-module, `signed_max2`: combinational two-input signed max, DATA_W-parameterised, instantiated twice (row-pair and column-pair stages).
- Row buffer and the sequencing checker remain inline.

Test Plan:
- Full frame, in_data = row*8+col, valid every cycle:
  - 16 out_valid pulses, out_data = 9,11,13,15,25,...,63.
  - Each pulse one cycle after its (odd,odd) input.
  - frame_done only with out_data=63 at (3,3).
- Negative data, in_data = -(row*8+col):
  - Window (0,0) outputs 0; window (3,3) outputs -54.
  - Confirms signed compare.
- in_valid toggled 1/0 every cycle across a frame:
  - Identical 16 results.
  - No out_valid during idle cycles.
  - State held across gaps.
- Reset pulled low at (row 3, col 5) mid-frame, released, new frame from (0,0):
  - All outputs 0 during reset.
  - Next frame produces the correct 16 results.
- Two frames back-to-back, the second with in_data = 100 - (row*8+col):
  - Second frame window (0,0) = 100, with no contamination from frame one.
  - frame_done pulses twice.
- With MAXPOOL_SEQ_CHECK_EN, coordinate (2,4) skipped:
  - seq_err rises on the next accepted sample and stays 1.
  - Without the macro, seq_err stays 0.
